// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencer:
// states, datapath op codes, operations, error causes.
package calc_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_A    = 4'd1,
    S_LOAD_A    = 4'd2,
    S_SHOW_A    = 4'd3,
    S_WAIT_B    = 4'd4,
    S_LOAD_B    = 4'd5,
    S_SHOW_B    = 4'd6,
    S_WAIT_OP   = 4'd7,
    S_EXEC      = 4'd8,
    S_WAIT_DONE = 4'd9,
    S_RESULT    = 4'd10,
    S_ERROR     = 4'd11
  } state_t;

  localparam logic [2:0] OP_NOOP     = 3'b000;
  localparam logic [2:0] OP_LOAD_A   = 3'b001;
  localparam logic [2:0] OP_DISP_A   = 3'b010;
  localparam logic [2:0] OP_LOAD_B   = 3'b011;
  localparam logic [2:0] OP_DISP_B   = 3'b100;
  localparam logic [2:0] OP_COMPUTE  = 3'b101;
  localparam logic [2:0] OP_DISP_RES = 3'b110;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] DIV = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DBZ     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Datapath instruction presented while sitting in a state.
  function automatic logic [2:0] state_op(input state_t s);
    logic [2:0] op;
    op = OP_NOOP;
    case (s)
      S_LOAD_A: op = OP_LOAD_A;
      S_SHOW_A: op = OP_DISP_A;
      S_LOAD_B: op = OP_LOAD_B;
      S_SHOW_B: op = OP_DISP_B;
      S_EXEC:   op = OP_COMPUTE;
      S_RESULT: op = OP_DISP_RES;
      default:  op = OP_NOOP;
    endcase
    return op;
  endfunction

  // Busy spans operand entry/display and the compute wait.
  function automatic logic state_busy(input state_t s);
    logic b;
    b = 1'b0;
    case (s)
      S_LOAD_A, S_SHOW_A, S_WAIT_B,
      S_LOAD_B, S_SHOW_B,
      S_EXEC, S_WAIT_DONE: b = 1'b1;
      default:             b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/calc_sequencer_edge.sv
// Rising-edge detector for an already synchronised level.
// One register; a held level yields a single pulse.
module edge_detect_rise (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic q;

  // Remember last cycle's level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/calc_sequencer.sv
// Moore sequencer driving the 4-bit calculator datapath
// from start/enter buttons, with a completion watchdog.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             enter,
  input  logic [1:0]       op_sel,
  input  logic             dp_done,
  input  logic             dp_div_by_zero,
  input  logic             dp_negative,
  output logic [2:0]       op_code,
  output logic [1:0]       compute_op,
  output logic [3:0]       state_code,
  output logic             busy,
  output logic             error,
  output logic [1:0]       err_code,
  output logic             result_neg,
  output logic [CNT_W-1:0] calc_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  state_t        nxt;
  logic [TW-1:0] to_cnt;

  logic rise_start;
  logic rise_enter;
  logic abort;
  logic latch_op;
  logic take_done;
  logic set_dbz;
  logic set_to;
  logic clr_err;
  logic cnt_clr;
  logic cnt_inc;

  edge_detect_rise u_start_edge (
    .clk   (clk),
    .reset (reset),
    .d     (start),
    .rise  (rise_start)
  );

  edge_detect_rise u_enter_edge (
    .clk   (clk),
    .reset (reset),
    .d     (enter),
    .rise  (rise_enter)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next state and register-update strobes; abort outranks all events.
  always_comb begin
    nxt       = state;
    latch_op  = 1'b0;
    take_done = 1'b0;
    set_dbz   = 1'b0;
    set_to    = 1'b0;
    clr_err   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    abort     = rise_start
              && (state != S_IDLE)
              && (state != S_ERROR);
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:
          if (rise_start) nxt = S_WAIT_A;
        S_WAIT_A:
          if (rise_enter) nxt = S_LOAD_A;
        S_LOAD_A:
          nxt = S_SHOW_A;
        S_SHOW_A:
          nxt = S_WAIT_B;
        S_WAIT_B:
          if (rise_enter) nxt = S_LOAD_B;
        S_LOAD_B:
          nxt = S_SHOW_B;
        S_SHOW_B:
          nxt = S_WAIT_OP;
        S_WAIT_OP:
          if (rise_enter) begin
            nxt      = S_EXEC;
            latch_op = 1'b1;
          end
        S_EXEC: begin
          nxt     = S_WAIT_DONE;
          cnt_clr = 1'b1;
        end
        S_WAIT_DONE:
          if (dp_div_by_zero) begin
            nxt     = S_ERROR;
            set_dbz = 1'b1;
          end else if (dp_done) begin
            nxt       = S_RESULT;
            take_done = 1'b1;
          end else if (to_cnt == TO_LAST) begin
            nxt    = S_ERROR;
            set_to = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        S_RESULT:
          if (rise_enter) nxt = S_WAIT_A;
        S_ERROR:
          if (rise_enter || rise_start) begin
            nxt     = S_IDLE;
            clr_err = 1'b1;
          end
        default:
          nxt = S_IDLE;
      endcase
    end
  end

  // Operation latch, error cause, sign, counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      compute_op <= ADD;
      err_code   <= ERR_NONE;
      result_neg <= 1'b0;
      calc_count <= '0;
      to_cnt     <= '0;
    end else begin
      if (latch_op)  compute_op <= op_sel;
      if (set_dbz)   err_code   <= ERR_DBZ;
      if (set_to)    err_code   <= ERR_TIMEOUT;
      if (clr_err)   err_code   <= ERR_NONE;
      if (take_done) begin
        result_neg <= dp_negative;
        calc_count <= calc_count + 1'b1;
      end
      if (cnt_clr)      to_cnt <= '0;
      else if (cnt_inc) to_cnt <= to_cnt + 1'b1;
    end
  end

  assign op_code    = state_op(state);
  assign busy       = state_busy(state);
  assign error      = (state == S_ERROR);
  assign state_code = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a small behavioural
// datapath (A/B registers, one-cycle compute, stall option).
module tb_calc_sequencer;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       enter = 1'b0;
  logic [1:0] op_sel = 2'b00;
  logic       dp_done = 1'b0;
  logic       dp_div_by_zero = 1'b0;
  logic       dp_negative = 1'b0;
  logic [2:0] op_code;
  logic [1:0] compute_op;
  logic [3:0] state_code;
  logic       busy;
  logic       error;
  logic [1:0] err_code;
  logic       result_neg;
  logic [7:0] calc_count;

  int errors = 0;
  int checks = 0;

  logic [3:0] data = 4'd0;
  logic [3:0] a_reg = 4'd0;
  logic [3:0] b_reg = 4'd0;
  int         res_mag = 0;
  logic       stall = 1'b0;

  calc_sequencer #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .enter          (enter),
    .op_sel         (op_sel),
    .dp_done        (dp_done),
    .dp_div_by_zero (dp_div_by_zero),
    .dp_negative    (dp_negative),
    .op_code        (op_code),
    .compute_op     (compute_op),
    .state_code     (state_code),
    .busy           (busy),
    .error          (error),
    .err_code       (err_code),
    .result_neg     (result_neg),
    .calc_count     (calc_count)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: flags pulse the cycle after COMPUTE.
  always @(posedge clk) begin
    int r;
    r = 0;
    dp_done        <= 1'b0;
    dp_div_by_zero <= 1'b0;
    if (op_code == OP_LOAD_A) a_reg <= data;
    if (op_code == OP_LOAD_B) b_reg <= data;
    if (op_code == OP_COMPUTE) begin
      case (compute_op)
        2'b00: r = int'(a_reg) + int'(b_reg);
        2'b01: r = int'(a_reg) - int'(b_reg);
        2'b10: r = int'(a_reg) * int'(b_reg);
        default: r = (b_reg == 0) ? 0 : int'(a_reg) / int'(b_reg);
      endcase
      if (compute_op == 2'b11 && b_reg == 4'd0) begin
        dp_div_by_zero <= 1'b1;
      end else if (!stall) begin
        dp_done     <= 1'b1;
        dp_negative <= (r < 0);
        res_mag     <= (r < 0) ? -r : r;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // From WAIT_A to EXEC: enter A, enter B, select op, enter.
  task automatic load_operands(input logic [3:0] a,
                               input logic [3:0] b,
                               input logic [1:0] op);
    data = a;
    enter = 1'b1; tick();
    enter = 1'b0; tick(); tick();
    data = b;
    enter = 1'b1; tick();
    enter = 1'b0; tick(); tick();
    op_sel = op;
    enter = 1'b1; tick();
    enter = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    if ({state_code, op_code, busy, error} !== 9'd0) begin
      $display("FAIL reset_state: got st=%0d op=%b busy=%b err=%b want 0",
               state_code, op_code, busy, error);
      errors++;
    end
    checks++;
    if ({compute_op, err_code, result_neg, calc_count} !== 13'd0) begin
      $display("FAIL reset_regs: got cop=%b ec=%b neg=%b cnt=%0d want 0",
               compute_op, err_code, result_neg, calc_count);
      errors++;
    end
    checks++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add;
    logic [2:0] seq [5];
    logic [2:0] want [5];
    want = '{OP_LOAD_A, OP_DISP_A, OP_LOAD_B, OP_DISP_B, OP_COMPUTE};
    start = 1'b1; tick();
    start = 1'b0;
    if (state_code !== 4'd1) begin
      $display("FAIL add_wait_a: got %0d want 1", state_code);
      errors++;
    end
    checks++;
    data = 4'd3;
    enter = 1'b1; tick(); seq[0] = op_code;
    if (busy !== 1'b1) begin
      $display("FAIL add_busy_load: got %b want 1", busy);
      errors++;
    end
    checks++;
    enter = 1'b0; tick(); seq[1] = op_code;
    tick();
    data = 4'd4;
    enter = 1'b1; tick(); seq[2] = op_code;
    enter = 1'b0; tick(); seq[3] = op_code;
    tick();
    if (state_code !== 4'd7) begin
      $display("FAIL add_wait_op: got %0d want 7", state_code);
      errors++;
    end
    checks++;
    op_sel = ADD;
    enter = 1'b1; tick(); seq[4] = op_code;
    enter = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (seq[i] !== want[i]) begin
        $display("FAIL add_opseq[%0d]: got %b want %b", i, seq[i], want[i]);
        errors++;
      end
      checks++;
    end
    tick(); tick();
    if (state_code !== 4'd10 || op_code !== OP_DISP_RES) begin
      $display("FAIL add_result_state: got st=%0d op=%b want 10/110",
               state_code, op_code);
      errors++;
    end
    checks++;
    if (res_mag !== 7 || calc_count !== 8'd1 || result_neg !== 1'b0) begin
      $display("FAIL add_result: got res=%0d cnt=%0d neg=%b want 7/1/0",
               res_mag, calc_count, result_neg);
      errors++;
    end
    checks++;
  endtask

  task automatic test_sub_negative;
    enter = 1'b1; tick();
    enter = 1'b0;
    if (state_code !== 4'd1) begin
      $display("FAIL sub_next_calc: got %0d want 1", state_code);
      errors++;
    end
    checks++;
    tick();
    load_operands(4'd2, 4'd5, SUB);
    tick(); tick();
    if (state_code !== 4'd10 || compute_op !== SUB) begin
      $display("FAIL sub_state: got st=%0d cop=%b want 10/01",
               state_code, compute_op);
      errors++;
    end
    checks++;
    if (res_mag !== 3 || result_neg !== 1'b1 || calc_count !== 8'd2) begin
      $display("FAIL sub_result: got res=%0d neg=%b cnt=%0d want 3/1/2",
               res_mag, result_neg, calc_count);
      errors++;
    end
    checks++;
    enter = 1'b1; tick();
    enter = 1'b0;
    if (state_code !== 4'd1) begin
      $display("FAIL sub_back_to_a: got %0d want 1", state_code);
      errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_div_by_zero;
    load_operands(4'd9, 4'd0, DIV);
    tick();
    if (state_code !== 4'd9) begin
      $display("FAIL dbz_wait: got %0d want 9", state_code);
      errors++;
    end
    checks++;
    tick();
    if (state_code !== 4'd11 || error !== 1'b1 || err_code !== ERR_DBZ) begin
      $display("FAIL dbz_error: got st=%0d err=%b ec=%b want 11/1/01",
               state_code, error, err_code);
      errors++;
    end
    checks++;
    if (calc_count !== 8'd2 || busy !== 1'b0) begin
      $display("FAIL dbz_count: got cnt=%0d busy=%b want 2/0",
               calc_count, busy);
      errors++;
    end
    checks++;
    enter = 1'b1; tick();
    enter = 1'b0;
    if (state_code !== 4'd0 || err_code !== ERR_NONE || error !== 1'b0) begin
      $display("FAIL dbz_clear: got st=%0d ec=%b err=%b want 0/00/0",
               state_code, err_code, error);
      errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_timeout;
    stall = 1'b1;
    start = 1'b1; tick();
    start = 1'b0; tick();
    load_operands(4'd1, 4'd1, ADD);
    tick();
    for (int i = 0; i < 7; i++) tick();
    if (state_code !== 4'd9) begin
      $display("FAIL timeout_early: got %0d want 9 after 7 cycles",
               state_code);
      errors++;
    end
    checks++;
    tick();
    if (state_code !== 4'd11 || err_code !== ERR_TIMEOUT) begin
      $display("FAIL timeout_error: got st=%0d ec=%b want 11/10",
               state_code, err_code);
      errors++;
    end
    checks++;
    stall = 1'b0;
    start = 1'b1; tick();
    start = 1'b0;
    if (state_code !== 4'd0 || err_code !== ERR_NONE) begin
      $display("FAIL timeout_clear: got st=%0d ec=%b want 0/00",
               state_code, err_code);
      errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_edges_abort;
    int loads;
    loads = 0;
    start = 1'b1; tick();
    start = 1'b0; tick();
    enter = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (op_code == OP_LOAD_A) loads++;
    end
    enter = 1'b0;
    if (loads !== 1 || state_code !== 4'd4) begin
      $display("FAIL held_enter: got loads=%0d st=%0d want 1/4",
               loads, state_code);
      errors++;
    end
    checks++;
    tick();
    start = 1'b1; tick();
    start = 1'b0;
    if (state_code !== 4'd0 || op_code !== OP_NOOP) begin
      $display("FAIL abort_wait_b: got st=%0d op=%b want 0/000",
               state_code, op_code);
      errors++;
    end
    checks++;
    tick();
    start = 1'b1; enter = 1'b1; tick();
    start = 1'b0; enter = 1'b0; tick();
    if (state_code !== 4'd1) begin
      $display("FAIL start_enter_idle: got %0d want 1", state_code);
      errors++;
    end
    checks++;
    load_operands(4'd1, 4'd2, ADD);
    tick();
    start = 1'b1; tick();
    start = 1'b0;
    if (state_code !== 4'd0 || calc_count !== 8'd2) begin
      $display("FAIL abort_over_done: got st=%0d cnt=%0d want 0/2",
               state_code, calc_count);
      errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_async_reset;
    stall = 1'b1;
    start = 1'b1; tick();
    start = 1'b0; tick();
    load_operands(4'd3, 4'd3, MUL);
    tick();
    if (state_code !== 4'd9 || compute_op !== MUL) begin
      $display("FAIL areset_setup: got st=%0d cop=%b want 9/10",
               state_code, compute_op);
      errors++;
    end
    checks++;
    #2;
    reset = 1'b1;
    #1;
    if ({state_code, op_code, busy, error, compute_op,
         err_code, result_neg, calc_count} !== 22'd0) begin
      $display("FAIL areset_now: got st=%0d op=%b busy=%b cop=%b cnt=%0d want 0",
               state_code, op_code, busy, compute_op, calc_count);
      errors++;
    end
    checks++;
    stall = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_negative();
    test_div_by_zero();
    test_timeout();
    test_edges_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Moore controller that sequences the 4-bit calculator datapath (calculator_datapath) from two user buttons.
- Turns start/enter presses into single-cycle LOAD_A, LOAD_B, DISPLAY and COMPUTE op_code pulses, and latches the arithmetic operation.
- Waits for the ALU completion or error flags, with a timeout watchdog.
- Reports state, error cause, result sign and the number of completed computations.
- Sits between the board buttons/switches and the datapath; it replaces the free-running fsm, whose op_code was not connected.

Parameters:
TIMEOUT_CYCLES, 8, number of WAIT_DONE cycles allowed without dp_done or dp_div_by_zero before a timeout error.
CNT_W, 8, width of the completed-computation counter.

Ports:
clk  in  1  system clock, all state updated on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  level button, already synchronised and debounced; its rising edge is used
enter  in  1  level button, already synchronised and debounced; its rising edge is used
op_sel  in  2  operation switches: 00 ADD, 01 SUB, 10 MUL, 11 DIV
dp_done  in  1  datapath done flag
dp_div_by_zero  in  1  datapath divide-by-zero flag
dp_negative  in  1  datapath negative flag
op_code  out  3  instruction to datapath: 000 NOOP, 001 LOAD_A, 011 LOAD_B, 010 DISP_A, 100 DISP_B, 101 COMPUTE, 110 DISP_RES
compute_op  out  2  latched operation to datapath
state_code  out  4  current state encoding, for HEX display
busy  out  1  high in LOAD_A..SHOW_B and EXEC/WAIT_DONE
error  out  1  high in ERROR
err_code  out  2  01 divide-by-zero, 10 timeout, 00 none
result_neg  out  1  sign of the last completed result
calc_count  out  CNT_W  completed computations, wraps modulo 2^CNT_W

Behaviour:
Reset values:
- state IDLE, op_code 000, compute_op 00, busy 0, error 0, err_code 00, result_neg 0, calc_count 0.
- Internal start_q/enter_q 0, timeout counter 0.

Edge detection:
- rise_x = x & ~x_q, with x_q registered every cycle.
- A held button produces exactly one event.

Outputs:
- op_code, busy and error decode combinationally from the state register only (Moore), so there is no combinational path from inputs to outputs.

States and transitions (an event is the rise of the named button):
- IDLE (0), op 000. start -> WAIT_A.
- WAIT_A (1), op 000. enter -> LOAD_A.
- LOAD_A (2), op 001, one cycle -> SHOW_A.
- SHOW_A (3), op 010, one cycle -> WAIT_B.
- WAIT_B (4), op 000. enter -> LOAD_B.
- LOAD_B (5), op 011, one cycle -> SHOW_B.
- SHOW_B (6), op 100, one cycle -> WAIT_OP.
- WAIT_OP (7), op 000. enter -> EXEC; compute_op <= op_sel in the same edge.
- EXEC (8), op 101, one cycle -> WAIT_DONE; timeout counter cleared.
- WAIT_DONE (9), op 000. Priority order:
  1. dp_div_by_zero -> ERROR, err_code 01.
  2. dp_done -> RESULT; result_neg <= dp_negative; calc_count++.
  3. Counter == TIMEOUT_CYCLES-1 -> ERROR, err_code 10.
  4. Otherwise counter++.
- RESULT (10), op 110, held. enter -> WAIT_A, next calculation.
- ERROR (11), op 000. enter or start -> IDLE; err_code cleared on exit.

Rules across states:
- compute_op holds its latched value in all states; it changes only on the WAIT_OP -> EXEC transition.
- Abort: start in any state except IDLE and ERROR -> IDLE. Abort has priority over enter and over WAIT_DONE events. Registers A/B in the datapath are not touched.
- Simultaneous start and enter in IDLE: start wins and enter is ignored, so the next cycle is WAIT_A.
- A held enter does not skip states, because edges are required.
- An enter rise during LOAD_*, SHOW_*, EXEC, or WAIT_DONE (non-abort) is ignored.
- The datapath asserts done one cycle after COMPUTE. The sequencer must accept done in the first WAIT_DONE cycle; latency from the enter edge to RESULT is 3 cycles.
- Reset mid-operation: immediate return to all reset values, including compute_op and calc_count.
- Undefined state encodings (12-15) -> IDLE on next clock.

Decomposition:
- Shared package calc_pkg holds:
  - state localparams S_IDLE..S_ERROR (4-bit);
  - op_code constants OP_NOOP, OP_LOAD_A, OP_LOAD_B, OP_DISP_A, OP_DISP_B, OP_COMPUTE, OP_DISP_RES;
  - compute_op constants ADD/SUB/MUL/DIV;
  - err_code constants.
- One sub-module, edge_detect_rise, instantiated twice (start, enter): 1 register, async reset.

Test Plan:
1. Full add: reset, start, data 3, enter, data 4, enter, op_sel=00, enter, with calculator_datapath attached -> op_code sequence 001,010,011,100,101; result 7 in RESULT; calc_count 1; result_neg 0.
2. Subtract negative: A=2, B=5, op_sel=01 -> RESULT, datapath result 3, result_neg 1; next enter -> WAIT_A.
3. Divide by zero: A=9, B=0, op_sel=11 -> ERROR with err_code 01 one cycle after EXEC; calc_count unchanged; enter -> IDLE, err_code 00.
4. Timeout: stub datapath holds dp_done=0, TIMEOUT_CYCLES=8 -> ERROR, err_code 10, exactly 8 cycles after entering WAIT_DONE.
5. Edges and abort: enter held high 20 cycles in WAIT_A -> exactly one LOAD_A pulse. Start rise in WAIT_B -> IDLE next cycle, op_code 000. Start and enter together in IDLE -> WAIT_A only.
6. Async reset asserted in WAIT_DONE between clock edges -> all outputs at reset values immediately, state_code 0.
